// File: rtl/axis_frame_checker_if.sv
// AXI4-Stream channel bundle; zero-width TID/TDEST collapse to a single ignored bit.
interface axi4s_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned ID_WIDTH   = 0,
    parameter int unsigned DEST_WIDTH = 0
);
    localparam int unsigned ID_W   = (ID_WIDTH   > 0) ? ID_WIDTH   : 1;
    localparam int unsigned DEST_W = (DEST_WIDTH > 0) ? DEST_WIDTH : 1;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;

    modport master (output tvalid, tdata, tuser, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_frame_checker.sv
// Checkerboard video sink: tracks raster position from SOF/EOL markers, compares
// pixels to a locally regenerated checkerboard and accumulates error statistics.
module axis_frame_checker #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned USER_WIDTH    = 1,
    parameter int unsigned ID_WIDTH      = 0,
    parameter int unsigned DEST_WIDTH    = 0,
    parameter int unsigned H_RES         = 1024,
    parameter int unsigned V_RES         = 768,
    parameter int unsigned CELL_W_BITS   = 7,
    parameter int unsigned CELL_H_BITS   = 6,
    parameter logic [15:0] COLOR_1       = 16'hFFFF,
    parameter logic [15:0] COLOR_2       = 16'h0000,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned COUNTER_WIDTH = (H_RES > V_RES) ? $clog2(H_RES) : $clog2(V_RES)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    axi4s_if.slave                   s_axis,
    input  logic                     stall_i,
    input  logic                     clear_i,
    output logic                     locked_o,
    output logic                     frame_done_o,
    output logic [CNT_WIDTH-1:0]     frame_cnt_o,
    output logic [CNT_WIDTH-1:0]     err_data_cnt_o,
    output logic [CNT_WIDTH-1:0]     err_sync_cnt_o,
    output logic [3:0]               err_flags_o,
    output logic [COUNTER_WIDTH-1:0] x_o,
    output logic [COUNTER_WIDTH-1:0] y_o
);
    localparam int unsigned CW = COUNTER_WIDTH;
    localparam logic [CW-1:0] X_LAST = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_RES - 1);

    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]        x_q, x_d, y_q, y_d;
    logic                 frame_done_q, frame_done_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] err_data_q, err_data_d;
    logic [CNT_WIDTH-1:0] err_sync_q, err_sync_d;
    logic [3:0]           flags_q, flags_d;

    logic [DATA_WIDTH-1:0] tdata_c;
    logic [USER_WIDTH-1:0] tuser_c;
    logic                  accept_c;
    logic                  sof_c;
    logic                  at_origin_c;
    logic                  check_c;
    logic                  drop_c;
    logic [CW-1:0]         px_c, py_c;
    logic                  x_last_c;
    logic                  eol_c;
    logic                  data_err_c;
    logic                  sof_err_c;
    logic                  early_c;
    logic                  late_c;
    logic                  sync_err_c;
    logic                  unused_c;

    function automatic logic [15:0] exp_color(input logic [CW-1:0] px, input logic [CW-1:0] py);
        logic [CW-1:0] cx;
        logic [CW-1:0] cy;
        cx = px >> CELL_W_BITS;
        cy = py >> CELL_H_BITS;
        return (cx[0] ^ cy[0]) ? COLOR_1 : COLOR_2;
    endfunction

    assign s_axis.tready = !rst_i && !stall_i;

    assign tdata_c  = s_axis.tdata;
    assign tuser_c  = s_axis.tuser;
    assign unused_c = ^{tdata_c, tuser_c, s_axis.tid, s_axis.tdest,
                        32'(ID_WIDTH), 32'(DEST_WIDTH)};

    assign accept_c    = s_axis.tvalid && s_axis.tready;
    assign sof_c       = tuser_c[0];
    assign at_origin_c = (x_q == '0) && (y_q == '0);

    // A SOF beat is always evaluated as the origin, whether it locks, relocks or is on time.
    assign check_c = accept_c && (sof_c || ((state_q == LOCKED) && !at_origin_c));
    assign drop_c  = accept_c && (state_q == LOCKED) && !sof_c && at_origin_c;
    assign px_c    = sof_c ? '0 : x_q;
    assign py_c    = sof_c ? '0 : y_q;

    assign x_last_c   = (px_c == X_LAST);
    assign eol_c      = x_last_c || s_axis.tlast;
    assign data_err_c = check_c && (tdata_c[15:0] != exp_color(px_c, py_c));
    assign sof_err_c  = (accept_c && (state_q == LOCKED) && sof_c && !at_origin_c) || drop_c;
    assign early_c    = check_c && s_axis.tlast && !x_last_c;
    assign late_c     = check_c && !s_axis.tlast && x_last_c;
    assign sync_err_c = sof_err_c || early_c || late_c;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            case (state_q)
                SEEK:    if (sof_c) state_d = LOCKED;
                LOCKED:  if (drop_c) state_d = SEEK;
                default: state_d = SEEK;
            endcase
        end
    end

    // Position, statistics and flags next values; clear overrides any same-cycle increment
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_data_d   = err_data_q;
        err_sync_d   = err_sync_q;
        flags_d      = flags_q;

        if (check_c) begin
            if (eol_c) begin
                x_d          = '0;
                y_d          = (py_c == Y_LAST) ? '0 : py_c + CW'(1);
                frame_done_d = (py_c == Y_LAST);
            end else begin
                x_d = px_c + CW'(1);
                y_d = py_c;
            end
        end else if (drop_c) begin
            x_d = '0;
            y_d = '0;
        end

        if (frame_done_d) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
        end
        if (data_err_c && (err_data_q != '1)) begin
            err_data_d = err_data_q + CNT_WIDTH'(1);
        end
        if (sync_err_c && (err_sync_q != '1)) begin
            err_sync_d = err_sync_q + CNT_WIDTH'(1);
        end
        flags_d = flags_q | {late_c, early_c, sof_err_c, data_err_c};

        if (clear_i) begin
            frame_cnt_d = '0;
            err_data_d  = '0;
            err_sync_d  = '0;
            flags_d     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_data_q   <= '0;
            err_sync_q   <= '0;
            flags_q      <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_data_q   <= err_data_d;
            err_sync_q   <= err_sync_d;
            flags_q      <= flags_d;
        end
    end

    // Output decode
    always_comb begin
        locked_o       = (state_q == LOCKED);
        frame_done_o   = frame_done_q;
        frame_cnt_o    = frame_cnt_q;
        err_data_cnt_o = err_data_q;
        err_sync_cnt_o = err_sync_q;
        err_flags_o    = flags_q;
        x_o            = x_q;
        y_o            = y_q;
    end
endmodule

// File: tb/tb_axis_frame_checker.sv
// Bench for axis_frame_checker on an 8x4 raster with 2x2 cells.
module tb_axis_frame_checker;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int XW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, stall, clr;
    logic          locked, frame_done;
    logic [15:0]   frame_cnt, err_data, err_sync;
    logic [3:0]    flags;
    logic [XW-1:0] xo, yo;

    axi4s_if #(.DATA_WIDTH(16), .USER_WIDTH(1), .ID_WIDTH(0), .DEST_WIDTH(0)) s_axis_if ();

    axis_frame_checker #(
        .DATA_WIDTH(16), .USER_WIDTH(1), .ID_WIDTH(0), .DEST_WIDTH(0),
        .H_RES(H), .V_RES(V), .CELL_W_BITS(1), .CELL_H_BITS(1),
        .COLOR_1(16'hFFFF), .COLOR_2(16'h0000), .CNT_WIDTH(16), .COUNTER_WIDTH(XW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .s_axis(s_axis_if), .stall_i(stall), .clear_i(clr),
        .locked_o(locked), .frame_done_o(frame_done), .frame_cnt_o(frame_cnt),
        .err_data_cnt_o(err_data), .err_sync_cnt_o(err_sync), .err_flags_o(flags),
        .x_o(xo), .y_o(yo)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    // Reference model: linear raster index plus plain integer statistics
    int       m_pos;
    bit       m_lock;
    int       m_frames, m_derr, m_serr;
    bit [3:0] m_flags;
    bit       m_done;

    typedef struct {
        bit          v, s, l;
        logic [15:0] d;
        bit          st, cl;
        bit          e_lock;
        int          e_x, e_y;
        logic [3:0]  e_flags;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] ref_pix(input int x, input int y);
        return (((x / 2) % 2) != ((y / 2) % 2)) ? 16'hFFFF : 16'h0000;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_lock = 0; m_frames = 0; m_derr = 0; m_serr = 0; m_flags = '0; m_done = 0;
    endtask

    task automatic model_accept(input bit s, input bit l, input logic [15:0] d);
        int  x, y;
        bit  sync;
        if (!m_lock && !s) return;
        if (m_lock && !s && m_pos == 0) begin
            m_lock = 0;
            m_flags[1] = 1;
            if (m_serr < 65535) m_serr++;
            return;
        end
        sync = 0;
        if (m_lock && s && m_pos != 0) begin
            sync = 1;
            m_flags[1] = 1;
        end
        if (s) m_pos = 0;
        x = m_pos % H;
        y = m_pos / H;
        if (d != ref_pix(x, y)) begin
            m_flags[0] = 1;
            if (m_derr < 65535) m_derr++;
        end
        if (l && x != H - 1) begin sync = 1; m_flags[2] = 1; end
        if (!l && x == H - 1) begin sync = 1; m_flags[3] = 1; end
        if (sync && m_serr < 65535) m_serr++;
        if (l || x == H - 1) m_pos = (y + 1) * H;
        else m_pos = m_pos + 1;
        if (m_pos == H * V) begin
            m_pos = 0;
            m_frames = (m_frames + 1) % 65536;
            m_done = 1;
        end
        m_lock = 1;
    endtask

    task automatic compare_all();
        chk("locked", locked, m_lock);
        chk("frame_done", frame_done, m_done);
        chk("frame_cnt", frame_cnt, m_frames);
        chk("err_data", err_data, m_derr);
        chk("err_sync", err_sync, m_serr);
        chk("flags", flags, m_flags);
        chk("x", xo, m_pos % H);
        chk("y", yo, m_pos / H);
    endtask

    // One clock cycle: drive, check TREADY, advance model at the edge, compare after it
    task automatic step(input bit v, input bit s, input bit l, input logic [15:0] d,
                        input bit st, input bit cl);
        s_axis_if.tvalid = v;
        s_axis_if.tuser  = s;
        s_axis_if.tlast  = l;
        s_axis_if.tdata  = d;
        s_axis_if.tid    = 1'($urandom);
        s_axis_if.tdest  = 1'($urandom);
        stall = st;
        clr   = cl;
        #1;
        chk("tready", s_axis_if.tready, !st);
        @(posedge clk);
        m_done = 0;
        if (v && !st) model_accept(s, l, d);
        if (cl) begin m_frames = 0; m_derr = 0; m_serr = 0; m_flags = '0; end
        #1;
        compare_all();
        if (frame_done) n_done++;
    endtask

    task automatic do_reset();
        rst = 1; stall = 0; clr = 0;
        s_axis_if.tvalid = 0; s_axis_if.tuser = 0; s_axis_if.tlast = 0; s_axis_if.tdata = '0;
        s_axis_if.tid = '0; s_axis_if.tdest = '0;
        #1;
        chk("rst_tready", s_axis_if.tready, 0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_locked", locked, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_data", err_data, 0);
        chk("rst_flags", flags, 0);
        chk("rst_xy", {xo, yo}, 0);
        rst = 0;
        model_reset();
        n_done = 0;
    endtask

    task automatic send_beat(input bit s, input bit l, input logic [15:0] d, input int pct);
        bit st;
        int tries;
        tries = 0;
        do begin
            st = (tries < 50) && ($urandom_range(99) < pct);
            step(1, s, l, d, st, 0);
            tries++;
        end while (st);
    endtask

    // One frame with optional corrupt pixel, early EOL and mid-frame SOF restart
    task automatic send_frame(input int pct, input int cx, input int cy, input logic [15:0] cval,
                              input int ex, input int ey, input int sx, input int sy);
        int x, y, inj;
        bit l;
        x = 0; y = 0; inj = sx;
        while (y < V) begin
            if (x == inj && y == sy) begin
                send_beat(1, 0, ref_pix(0, 0), pct);
                inj = -1; x = 1; y = 0;
            end else begin
                l = (x == H - 1) || (x == ex && y == ey);
                send_beat(x == 0 && y == 0, l, (x == cx && y == cy) ? cval : ref_pix(x, y), pct);
                if (l) begin x = 0; y++; end
                else x++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  gx, gy;
        bit  v, s, l, st, cl;
        logic [15:0] d;

        tbl[0]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 4'b0000};
        tbl[1]  = '{1, 0, 1, 16'hFFFF, 0, 0, 0, 0, 0, 4'b0000};
        tbl[2]  = '{0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 4'b0000};
        tbl[3]  = '{1, 1, 0, 16'h0000, 0, 0, 1, 1, 0, 4'b0000};
        tbl[4]  = '{1, 0, 0, 16'h0000, 0, 0, 1, 2, 0, 4'b0000};
        tbl[5]  = '{1, 0, 0, 16'h1234, 1, 0, 1, 2, 0, 4'b0000};
        tbl[6]  = '{1, 0, 0, 16'h1234, 0, 0, 1, 3, 0, 4'b0001};
        tbl[7]  = '{1, 0, 0, 16'hFFFF, 0, 1, 1, 4, 0, 4'b0000};
        tbl[8]  = '{1, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 4'b0100};
        tbl[9]  = '{1, 1, 0, 16'h0000, 0, 0, 1, 1, 0, 4'b0110};
        tbl[10] = '{0, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 4'b0000};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].d, tbl[i].st, tbl[i].cl);
            chk($sformatf("tbl%0d_locked", i), locked, tbl[i].e_lock);
            chk($sformatf("tbl%0d_x", i), xo, tbl[i].e_x);
            chk($sformatf("tbl%0d_y", i), yo, tbl[i].e_y);
            chk($sformatf("tbl%0d_flags", i), flags, tbl[i].e_flags);
        end

        // Two clean frames
        do_reset();
        send_frame(0, -1, -1, 16'h0, -1, -1, -1, -1);
        send_frame(0, -1, -1, 16'h0, -1, -1, -1, -1);
        chk("clean_done_pulses", n_done, 2);
        chk("clean_frame_cnt", frame_cnt, 2);
        chk("clean_errs", {err_data, err_sync}, 0);

        // Leading beats without SOF are ignored
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, i == 4, 16'($urandom), 0, 0);
        chk("seek_locked", locked, 0);
        send_frame(0, -1, -1, 16'h0, -1, -1, -1, -1);
        chk("seek_frame_cnt", frame_cnt, 1);
        chk("seek_flags", flags, 0);

        // Corrupted pixel (3,1)
        do_reset();
        send_frame(0, 3, 1, 16'h1234, -1, -1, -1, -1);
        chk("pix_err_data", err_data, 1);
        chk("pix_flags", flags, 4'b0001);
        chk("pix_frame_cnt", frame_cnt, 1);

        // Early TLAST at (5,0)
        do_reset();
        send_frame(0, -1, -1, 16'h0, 5, 0, -1, -1);
        chk("eol_flags", flags, 4'b0100);
        chk("eol_err_sync", err_sync, 1);
        chk("eol_err_data", err_data, 0);
        chk("eol_frame_cnt", frame_cnt, 1);

        // 50% backpressure over three frames
        do_reset();
        for (int f = 0; f < 3; f++) send_frame(50, -1, -1, 16'h0, -1, -1, -1, -1);
        chk("stall_frame_cnt", frame_cnt, 3);
        chk("stall_errs", {err_data, err_sync, 12'(flags)}, 0);

        // SOF injected at (2,2), then clear on a corrupted beat
        do_reset();
        send_frame(0, -1, -1, 16'h0, -1, -1, 2, 2);
        chk("sof_flags", flags, 4'b0010);
        chk("sof_err_sync", err_sync, 1);
        chk("sof_err_data", err_data, 0);
        chk("sof_frame_cnt", frame_cnt, 1);
        step(1, 1, 0, ref_pix(0, 0), 0, 0);
        step(1, 0, 0, 16'h1234, 0, 1);
        chk("clear_err_data", err_data, 0);
        chk("clear_flags", flags, 0);
        chk("clear_frame_cnt", frame_cnt, 0);
        chk("clear_keeps_x", xo, 2);
        for (int p = 2; p < H * V; p++) send_beat(0, (p % H) == H - 1, ref_pix(p % H, p / H), 0);
        chk("after_clear_frame_cnt", frame_cnt, 1);

        // Randomised stream with sync/data faults, stalls and clears
        do_reset();
        gx = 0; gy = 0;
        for (int i = 0; i < 800; i++) begin
            v  = ($urandom_range(3) != 0);
            st = ($urandom_range(2) == 0);
            cl = ($urandom_range(99) < 3);
            s  = (gx == 0 && gy == 0) ^ ($urandom_range(99) < 5);
            l  = (gx == H - 1) ^ ($urandom_range(99) < 5);
            d  = ref_pix(gx, gy);
            if ($urandom_range(99) < 5) d = d ^ 16'(1 + $urandom_range(16'hFFFE));
            step(v, s, l, d, st, cl);
            if (v && !st) begin
                if (l || gx >= H - 1) begin gx = 0; gy = (gy + 1) % V; end
                else gx++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
- AXI4-Stream video sink that consumes a raster stream, e.g. from the checkerboard generator, and checks it.
- Checks frame structure (TUSER[0]=SOF, TLAST=EOL) and pixel data against a locally recomputed checkerboard.
- Reports error counters, sticky flags and frame statistics.
- Sits at the far end of test video paths (after FIFOs, CDC, scalers) as a self-checking sink for hardware and simulation.

Parameters:
DATA_WIDTH, 16, TDATA width; only bits [15:0] are checked (RGB565)
USER_WIDTH, 1, TUSER width; bit 0 = SOF
ID_WIDTH, 0, TID width (ignored)
DEST_WIDTH, 0, TDEST width (ignored)
H_RES, 1024, pixels per line
V_RES, 768, lines per frame
CELL_W_BITS, 7, log2 of cell width
CELL_H_BITS, 6, log2 of cell height
COLOR_1, 16'hFFFF, colour when cell_x_odd XOR cell_y_odd
COLOR_2, 16'h0000, colour otherwise; pixel (0,0) expects COLOR_2
CNT_WIDTH, 16, width of statistics counters
COUNTER_WIDTH, $clog2(max(H_RES,V_RES)), x/y counter width

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous reset, active-high
s_axis  axi4s_if.slave  -  input stream; this block drives TREADY
stall_i  in  1  backpressure request; 1 deasserts TREADY
clear_i  in  1  synchronous clear of counters and flags
locked_o  out  1  1 while aligned to a frame
frame_done_o  out  1  one-cycle pulse per completed frame
frame_cnt_o  out  CNT_WIDTH  completed frames, wraps
err_data_cnt_o  out  CNT_WIDTH  pixel mismatches, saturating
err_sync_cnt_o  out  CNT_WIDTH  beats with any sync error, saturating
err_flags_o  out  4  sticky: [0] data, [1] SOF, [2] early EOL, [3] late EOL
x_o, y_o  out  COUNTER_WIDTH each  expected position of the next beat

Behaviour:
- Reset (rst_i=1): state SEEK, x=y=0, all outputs 0, TREADY=0. Reset mid-frame discards alignment; a new SOF is required.
- TREADY = !rst_i && !stall_i (combinational). A beat is accepted when TVALID && TREADY; nothing changes otherwise.
- All status outputs are registered and update on the clock edge that accepts the beat (visible the next cycle).
- Expected colour at (x,y): ((x>>CELL_W_BITS)[0] ^ (y>>CELL_H_BITS)[0]) ? COLOR_1 : COLOR_2.
- SEEK state:
  - Beats with TUSER[0]=0 are discarded with no checks.
  - A beat with TUSER[0]=1 is taken as pixel (0,0). Data and TLAST are checked, position advances, state goes to LOCKED, locked_o=1.
- LOCKED state, each accepted beat at (x,y):
  - Data: TDATA[15:0] != expected -> err_data_cnt++, flag[0].
  - TUSER[0]=1 with (x,y)!=(0,0) -> sync error, flag[1]. Beat is re-taken as (0,0) (checked as origin). No frame is counted.
  - TUSER[0]=0 at (0,0) -> sync error, flag[1]. Go to SEEK, locked_o=0, no data check, position reset to 0,0.
  - TLAST=1 with x!=H_RES-1 -> sync error, flag[2]. Next x=0, y advances as at end of line.
  - TLAST=0 at x==H_RES-1 -> sync error, flag[3]. Position advances normally.
- Position advance:
  - x==H_RES-1: x=0, then y++.
  - y==V_RES-1 at end of line: y=0, frame_cnt++ (mod 2^CNT_WIDTH), frame_done_o=1 for one cycle.
  - Otherwise x++.
- err_sync_cnt increments once per beat with any sync error, even if several flags set. A data error and a sync error in the same beat both count.
- Error counters saturate at all-ones. Flags are sticky until clear_i or rst_i.
- clear_i zeroes the counters and flags. It does not alter state, x/y or locked_o. If an increment and clear_i occur in the same cycle, clear wins (result 0).
- TID/TDEST and TDATA bits above 15 are ignored.

Test Plan:
- Use H_RES=8, V_RES=4, CELL_W_BITS=1, CELL_H_BITS=1 unless stated.
- Reset, then 2 clean frames (64 beats), stall_i=0 -> frame_done_o pulses twice; frame_cnt_o=2; error counters 0; locked_o=1 from the cycle after beat 0.
- 5 beats without SOF, then a clean frame -> first 5 beats ignored; locked_o rises after the SOF beat; err_flags_o=0; frame_cnt_o=1.
- Pixel (3,1) forced to 16'h1234 -> err_data_cnt_o=1, err_flags_o=4'b0001, frame still counted.
- TLAST asserted at (5,0), then line 1 starts -> err_flags_o[2]=1, err_sync_cnt_o=1; following lines give no data errors; frame_cnt_o increments normally.
- Random stall_i at 50% over 3 frames -> TREADY mirrors !stall_i; frame_cnt_o=3; zero errors.
- SOF injected at (2,2) -> flag[1], err_sync_cnt=1; frame restarts at 0,0 with no spurious data errors. Then clear_i pulsed on a corrupted-pixel beat -> counters and flags read 0 the next cycle.
